// File: rtl/vm2413.sv
// Shared VM2413 voice types plus the user-instrument register merge helpers used by the
// register-write front end and by downstream models.
package vm2413;

  typedef logic [5:0] VOICE_ID_TYPE;

  typedef struct packed {
    logic       am;
    logic       pm;
    logic       eg;
    logic       kr;
    logic [3:0] ml;
    logic [1:0] kl;
    logic [5:0] tl;
    logic       wf;
    logic [2:0] fb;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
  } VOICE_TYPE;

  localparam VOICE_ID_TYPE USER_MOD_ID = 6'd0;
  localparam VOICE_ID_TYPE USER_CAR_ID = 6'd1;

  typedef enum logic [1:0] {StIdle, StRd, StMrg, StWr} uvw_state_e;

  // First voice touched by a register; $03 starts on the modulator and continues to the carrier.
  function automatic VOICE_ID_TYPE user_reg_first_id(input logic [2:0] addr);
    unique case (addr)
      3'd1, 3'd5, 3'd7: return USER_CAR_ID;
      default:          return USER_MOD_ID;
    endcase
  endfunction

  function automatic VOICE_TYPE user_reg_merge(input logic [2:0]   addr,
                                               input logic [7:0]   data,
                                               input VOICE_ID_TYPE id,
                                               input VOICE_TYPE    voice);
    VOICE_TYPE v;
    v = voice;
    unique case (addr)
      3'd0, 3'd1: begin
        v.am = data[7];
        v.pm = data[6];
        v.eg = data[5];
        v.kr = data[4];
        v.ml = data[3:0];
      end
      3'd2: begin
        v.kl = data[7:6];
        v.tl = data[5:0];
      end
      3'd3: begin
        if (id == USER_MOD_ID) begin
          v.wf = data[3];
          v.fb = data[2:0];
        end else begin
          v.kl = data[7:6];
          v.wf = data[4];
        end
      end
      3'd4, 3'd5: begin
        v.ar = data[7:4];
        v.dr = data[3:0];
      end
      default: begin
        v.sl = data[7:4];
        v.rr = data[3:0];
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/user_voice_writer_if.sv
// CPU request and voice-memory port bundle for the user voice writer.
interface user_voice_writer_if;
  import vm2413::*;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_addr;
  logic [7:0]   req_data;
  logic         busy;
  VOICE_ID_TYPE mem_rwaddr;
  logic         mem_wr;
  VOICE_TYPE    mem_idata;
  VOICE_TYPE    mem_odata;

  // The writer itself.
  modport slave (
    input  req_valid, req_addr, req_data, mem_odata,
    output req_ready, busy, mem_rwaddr, mem_wr, mem_idata
  );

  // CPU plus voice memory environment.
  modport master (
    output req_valid, req_addr, req_data, mem_odata,
    input  req_ready, busy, mem_rwaddr, mem_wr, mem_idata
  );
endinterface

// File: rtl/user_voice_writer.sv
// Turns CPU writes to OPLL registers $00-$07 into read-modify-write cycles on the user
// instrument's modulator/carrier voice entries, after the voice memory's ROM copy finishes.
module user_voice_writer
  import vm2413::*;
#(
  parameter int unsigned INIT_CYCLES = 120
) (
  input  logic                clk,
  input  logic                reset_n,
  user_voice_writer_if.slave  bus
);

  localparam int unsigned CntW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

  logic [CntW-1:0] init_cnt_q;
  logic            init_done;
  logic            pend_valid_q;
  logic [2:0]      pend_addr_q;
  logic [7:0]      pend_data_q;
  logic [2:0]      work_addr_q;
  logic [7:0]      work_data_q;
  uvw_state_e      state_q;
  VOICE_ID_TYPE    mem_rwaddr_q;
  logic            mem_wr_q;
  VOICE_TYPE       mem_idata_q;

  assign init_done     = (init_cnt_q == CntW'(INIT_CYCLES));
  assign bus.req_ready = init_done && !pend_valid_q;
  assign bus.busy      = (state_q != StIdle) || pend_valid_q;
  assign bus.mem_rwaddr = mem_rwaddr_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_idata  = mem_idata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      work_addr_q  <= '0;
      work_data_q  <= '0;
      state_q      <= StIdle;
      mem_rwaddr_q <= USER_MOD_ID;
      mem_wr_q     <= 1'b0;
      mem_idata_q  <= '0;
    end else begin
      if (!init_done) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end

      // Handshake cannot coincide with IDLE consuming the entry: ready is low while it is full.
      if (bus.req_valid && bus.req_ready) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= bus.req_addr;
        pend_data_q  <= bus.req_data;
      end

      unique case (state_q)
        StIdle: begin
          if (pend_valid_q) begin
            pend_valid_q <= 1'b0;
            work_addr_q  <= pend_addr_q;
            work_data_q  <= pend_data_q;
            mem_rwaddr_q <= user_reg_first_id(pend_addr_q);
            state_q      <= StRd;
          end
        end
        StRd: begin
          state_q <= StMrg;
        end
        StMrg: begin
          mem_idata_q <= user_reg_merge(work_addr_q, work_data_q, mem_rwaddr_q, bus.mem_odata);
          mem_wr_q    <= 1'b1;
          state_q     <= StWr;
        end
        StWr: begin
          mem_wr_q <= 1'b0;
          if (work_addr_q == 3'd3 && mem_rwaddr_q == USER_MOD_ID) begin
            mem_rwaddr_q <= USER_CAR_ID;
            state_q      <= StRd;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_user_voice_writer.sv
// Bench for user_voice_writer: voice-memory model, reference voice model with an expected-write
// queue, and a monitor that checks every memory write against it.
module tb_user_voice_writer;
  import vm2413::*;

  localparam int unsigned InitCycles = 120;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  user_voice_writer_if bus();

  user_voice_writer #(.INIT_CYCLES(InitCycles)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Voice memory model: registered read, write on mem_wr, bulk load for presets.
  VOICE_TYPE mem [2];
  VOICE_TYPE preset [2];
  logic      load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      mem[0] <= preset[0];
      mem[1] <= preset[1];
    end else if (bus.mem_wr) begin
      mem[bus.mem_rwaddr[0]] <= bus.mem_idata;
    end
    bus.mem_odata <= mem[bus.mem_rwaddr[0]];
  end

  typedef struct {
    int        id;
    VOICE_TYPE v;
  } exp_t;

  VOICE_TYPE ref_v [2];
  exp_t      exp_q [$];
  int        wr_cyc [$];

  // Reference: apply the register write to the abstract voice pair and queue the writes it implies.
  task automatic ref_apply(input logic [2:0] a, input logic [7:0] d);
    int id;
    id = int'(a[0]);
    case (a)
      3'd0, 3'd1: begin
        ref_v[id].am = d[7]; ref_v[id].pm = d[6]; ref_v[id].eg = d[5];
        ref_v[id].kr = d[4]; ref_v[id].ml = d[3:0];
        exp_q.push_back('{id, ref_v[id]});
      end
      3'd2: begin
        ref_v[0].kl = d[7:6]; ref_v[0].tl = d[5:0];
        exp_q.push_back('{0, ref_v[0]});
      end
      3'd3: begin
        ref_v[0].wf = d[3]; ref_v[0].fb = d[2:0];
        exp_q.push_back('{0, ref_v[0]});
        ref_v[1].kl = d[7:6]; ref_v[1].wf = d[4];
        exp_q.push_back('{1, ref_v[1]});
      end
      3'd4, 3'd5: begin
        ref_v[id].ar = d[7:4]; ref_v[id].dr = d[3:0];
        exp_q.push_back('{id, ref_v[id]});
      end
      default: begin
        ref_v[id].sl = d[7:4]; ref_v[id].rr = d[3:0];
        exp_q.push_back('{id, ref_v[id]});
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (bus.mem_wr) begin
      exp_t e;
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: got id=%0d data=%h, required no write", bus.mem_rwaddr,
                 bus.mem_idata);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_rwaddr !== VOICE_ID_TYPE'(e.id) || bus.mem_idata !== e.v) begin
          errors++;
          $display("FAIL mem_write: got id=%0d data=%h, required id=%0d data=%h",
                   bus.mem_rwaddr, bus.mem_idata, e.id, e.v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic set_mem(input VOICE_TYPE v0, input VOICE_TYPE v1);
    preset[0] = v0; preset[1] = v1;
    ref_v[0] = v0;  ref_v[1] = v1;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Issue one request; hs is the cycle index (negedge-sampled) of the handshake cycle.
  task automatic send(input logic [2:0] a, input logic [7:0] d, output int hs);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d;
    n = 0;
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got req_ready=0, required 1 within 500 cycles");
      bus.req_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc;
    ref_apply(a, d);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Counts cycles from reset release until req_ready; req_valid is left as the caller set it.
  task automatic release_and_count(output int n);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    VOICE_TYPE z, va, e0, e1;
    int n, hs, h1, h2, rdy_cyc;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    z = '0;

    // Init gap with req_valid held, then $00=F1 into an all-zero modulator.
    set_mem(z, z);
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_wr", 64'(bus.mem_wr), 64'd0);
    chk("reset_idata", 64'(bus.mem_idata), 64'd0);
    chk("reset_rwaddr", 64'(bus.mem_rwaddr), 64'd0);
    wr_cyc.delete();
    bus.req_valid = 1'b1; bus.req_addr = 3'd0; bus.req_data = 8'hF1;
    release_and_count(n);
    chk("init_gap", 64'(n), 64'(InitCycles));
    chk("no_wr_during_init", 64'(wr_cyc.size()), 64'd0);
    hs = cyc;
    ref_apply(3'd0, 8'hF1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    drain();
    chk("f1_wr_count", 64'(wr_cyc.size()), 64'd1);
    if (wr_cyc.size() >= 1) chk("f1_latency", 64'(wr_cyc[0] - hs), 64'd4);
    e0 = z; e0.am = 1; e0.pm = 1; e0.eg = 1; e0.kr = 1; e0.ml = 4'd1;
    chk("f1_mod", 64'(mem[0]), 64'(e0));

    // $03=D5 over AR/DR/SL/RR=A in both voices.
    va = z; va.ar = 4'hA; va.dr = 4'hA; va.sl = 4'hA; va.rr = 4'hA;
    set_mem(va, va);
    wr_cyc.delete();
    send(3'd3, 8'hD5, hs);
    drain();
    chk("r3_wr_count", 64'(wr_cyc.size()), 64'd2);
    if (wr_cyc.size() == 2) begin
      chk("r3_first_wr", 64'(wr_cyc[0] - hs), 64'd4);
      chk("r3_second_wr", 64'(wr_cyc[1] - hs), 64'd7);
    end
    e0 = va; e0.fb = 3'd5; e0.wf = 1'b0;
    e1 = va; e1.kl = 2'd3; e1.wf = 1'b1;
    chk("r3_mod", 64'(mem[0]), 64'(e0));
    chk("r3_car", 64'(mem[1]), 64'(e1));

    // Back-to-back $04=3C, $05=96: second buffered while the first is in flight.
    set_mem(z, z);
    send(3'd4, 8'h3C, h1);
    chk("b2b_ready_full", 64'(bus.req_ready), 64'd0);
    send(3'd5, 8'h96, h2);
    chk("b2b_accept_cycle", 64'(h2 - h1), 64'd2);
    chk("b2b_ready_drop", 64'(bus.req_ready), 64'd0);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    rdy_cyc = cyc;
    chk("b2b_ready_return", 64'(rdy_cyc - h1), 64'd6);
    drain();
    e0 = z; e0.ar = 4'h3; e0.dr = 4'hC;
    e1 = z; e1.ar = 4'h9; e1.dr = 4'h6;
    chk("b2b_mod", 64'(mem[0]), 64'(e0));
    chk("b2b_car", 64'(mem[1]), 64'(e1));

    // $06=21 then $06=47: second RMW must see the first result.
    set_mem(z, z);
    send(3'd6, 8'h21, h1);
    send(3'd6, 8'h47, h2);
    drain();
    e0 = z; e0.sl = 4'h4; e0.rr = 4'h7;
    chk("sl_rr_mod", 64'(mem[0]), 64'(e0));

    // Randomised traffic over random initial voices.
    e0 = VOICE_TYPE'({$urandom(), $urandom()});
    e1 = VOICE_TYPE'({$urandom(), $urandom()});
    set_mem(e0, e1);
    for (int i = 0; i < 60; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom()), hs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("rand_mod", 64'(mem[0]), 64'(ref_v[0]));
    chk("rand_car", 64'(mem[1]), 64'(ref_v[1]));

    // Reset during the MRG cycle of a $03 write.
    set_mem(z, z);
    send(3'd3, 8'hD5, hs);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    exp_q.delete();
    wr_cyc.delete();
    set_mem(z, z);
    repeat (3) @(negedge clk);
    chk("rst_no_wr", 64'(wr_cyc.size()), 64'd0);
    release_and_count(n);
    chk("rst_init_gap", 64'(n), 64'(InitCycles));
    chk("rst_no_wr_init", 64'(wr_cyc.size()), 64'd0);
    send(3'd2, 8'h8F, hs);
    drain();
    e0 = z; e0.kl = 2'd2; e0.tl = 6'h0F;
    chk("post_rst_mod", 64'(mem[0]), 64'(e0));
    chk("post_rst_car", 64'(mem[1]), 64'(z));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
